// File: rtl/bist_checker_pkg.sv
// Shared types and constants for the BIST response checker.
package bist_checker_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } bist_checker_state_t;

    localparam int FAIL_COUNT_WIDTH = 16;

endpackage

// File: rtl/bist_checker_if.sv
// Bus between the March generator / SRAM read side / host and the checker.
interface bist_checker_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    import bist_checker_pkg::*;

    logic                        clear;
    logic                        en;
    logic                        re;
    logic [ADDR_WIDTH-1:0]       addr;
    logic [DATA_WIDTH-1:0]       expected;
    logic                        gen_done;
    logic [DATA_WIDTH-1:0]       dout;
    logic                        fail;
    logic [FAIL_COUNT_WIDTH-1:0] fail_count;
    logic [ADDR_WIDTH-1:0]       first_fail_addr;
    logic                        test_done;
    logic                        pass;
    logic                        log_valid;
    logic                        log_ready;
    logic [ADDR_WIDTH-1:0]       log_addr;
    logic [DATA_WIDTH-1:0]       log_syndrome;
    logic                        log_overflow;

    modport master (
        output clear, en, re, addr, expected, gen_done, dout, log_ready,
        input  fail, fail_count, first_fail_addr, test_done, pass,
               log_valid, log_addr, log_syndrome, log_overflow
    );

    modport slave (
        input  clear, en, re, addr, expected, gen_done, dout, log_ready,
        output fail, fail_count, first_fail_addr, test_done, pass,
               log_valid, log_addr, log_syndrome, log_overflow
    );

endinterface

// File: rtl/bist_fail_log.sv
// Small synchronous FIFO holding {address, syndrome} of failing reads.
// A push into a full FIFO is still taken when a pop happens on the same edge.
module bist_fail_log #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 40
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] pushData_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] headData_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W:0]   wrPtr_q;
    logic [PTR_W:0]   wrPtr_d;
    logic [PTR_W:0]   rdPtr_q;
    logic [PTR_W:0]   rdPtr_d;
    logic             doPush;
    logic             doPop;

    assign empty_o = (wrPtr_q == rdPtr_q);
    assign full_o  = (wrPtr_q[PTR_W] != rdPtr_q[PTR_W]) &&
                     (wrPtr_q[PTR_W-1:0] == rdPtr_q[PTR_W-1:0]);
    assign doPop   = pop_i && !empty_o;
    assign doPush  = push_i && (!full_o || doPop);

    // Head output reads as zero while empty so the log port is quiet after reset/clear.
    assign headData_o = empty_o ? '0 : mem_q[rdPtr_q[PTR_W-1:0]];

    // Next pointer values; clear empties the FIFO regardless of traffic.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        if (clear_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
        end else begin
            if (doPush) wrPtr_d = wrPtr_q + {{PTR_W{1'b0}}, 1'b1};
            if (doPop)  rdPtr_d = rdPtr_q + {{PTR_W{1'b0}}, 1'b1};
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
        end
    end

    // Storage write; contents only matter behind valid pointers, so no reset.
    always_ff @(posedge clk) begin
        if (doPush && !clear_i) begin
            mem_q[wrPtr_q[PTR_W-1:0]] <= pushData_i;
        end
    end

endmodule

// File: rtl/bist_checker.sv
// BIST response analyzer: delays generator read requests by the SRAM read
// latency, compares returned data, and records pass/fail results and a log.
module bist_checker
    import bist_checker_pkg::*;
#(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1,
    parameter int LOG_DEPTH    = 4
) (
    input  logic           clk,
    input  logic           rstb,
    bist_checker_if.slave  bus
);

    localparam int LAST = READ_LATENCY - 1;
    localparam int LOG_W = ADDR_WIDTH + DATA_WIDTH;

    bist_checker_state_t         state_q;
    bist_checker_state_t         state_d;
    logic [READ_LATENCY-1:0]     pipeValid_q;
    logic [READ_LATENCY-1:0]     pipeValid_d;
    logic [ADDR_WIDTH-1:0]       pipeAddr_q [READ_LATENCY];
    logic [DATA_WIDTH-1:0]       pipeExp_q  [READ_LATENCY];
    logic                        fail_q;
    logic                        fail_d;
    logic [FAIL_COUNT_WIDTH-1:0] failCount_q;
    logic [FAIL_COUNT_WIDTH-1:0] failCount_d;
    logic [ADDR_WIDTH-1:0]       firstFailAddr_q;
    logic [ADDR_WIDTH-1:0]       firstFailAddr_d;
    logic                        overflow_q;
    logic                        overflow_d;
    logic                        acceptReq;
    logic                        mismatch;
    logic [DATA_WIDTH-1:0]       syndrome;
    logic                        logFull;
    logic                        logEmpty;
    logic [LOG_W-1:0]            logHead;

    assign acceptReq = bus.en && bus.re && ((state_q == IDLE) || (state_q == RUN));
    assign syndrome  = bus.dout ^ pipeExp_q[LAST];
    assign mismatch  = pipeValid_q[LAST] && (syndrome != '0) &&
                       (state_q != DONE) && !bus.clear;

    // Valid bits shift every edge; a new request only enters before DRAIN.
    always_comb begin
        pipeValid_d = '0;
        if (!bus.clear) begin
            pipeValid_d[0] = acceptReq;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipeValid_d[i] = pipeValid_q[i-1];
            end
        end
    end

    // Valid bits are the only pipeline state that needs a reset.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) pipeValid_q <= '0;
        else       pipeValid_q <= pipeValid_d;
    end

    // Address and expected word ride alongside their valid bit.
    always_ff @(posedge clk) begin
        pipeAddr_q[0] <= bus.addr;
        pipeExp_q[0]  <= bus.expected;
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipeAddr_q[i] <= pipeAddr_q[i-1];
            pipeExp_q[i]  <= pipeExp_q[i-1];
        end
    end

    // Run sequencing; DONE waits for every in-flight compare to retire.
    always_comb begin
        state_d = state_q;
        if (bus.clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (bus.en)               state_d = RUN;
                RUN:     if (bus.gen_done)         state_d = DRAIN;
                DRAIN:   if (pipeValid_d == '0)    state_d = DONE;
                DONE:                              state_d = DONE;
                default:                           state_d = IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Result bookkeeping on a mismatch; the first address is latched only once.
    always_comb begin
        fail_d          = fail_q;
        failCount_d     = failCount_q;
        firstFailAddr_d = firstFailAddr_q;
        overflow_d      = overflow_q;
        if (bus.clear) begin
            fail_d          = 1'b0;
            failCount_d     = '0;
            firstFailAddr_d = '0;
            overflow_d      = 1'b0;
        end else if (mismatch) begin
            fail_d = 1'b1;
            if (failCount_q != '1) failCount_d = failCount_q + 1'b1;
            if (!fail_q)           firstFailAddr_d = pipeAddr_q[LAST];
            if (logFull && !bus.log_ready) overflow_d = 1'b1;
        end
    end

    // Result registers.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            fail_q          <= 1'b0;
            failCount_q     <= '0;
            firstFailAddr_q <= '0;
            overflow_q      <= 1'b0;
        end else begin
            fail_q          <= fail_d;
            failCount_q     <= failCount_d;
            firstFailAddr_q <= firstFailAddr_d;
            overflow_q      <= overflow_d;
        end
    end

    bist_fail_log #(
        .DEPTH (LOG_DEPTH),
        .WIDTH (LOG_W)
    ) u_log (
        .clk        (clk),
        .rstb       (rstb),
        .clear_i    (bus.clear),
        .push_i     (mismatch),
        .pushData_i ({pipeAddr_q[LAST], syndrome}),
        .pop_i      (bus.log_ready),
        .headData_o (logHead),
        .full_o     (logFull),
        .empty_o    (logEmpty)
    );

    assign bus.fail            = fail_q;
    assign bus.fail_count      = failCount_q;
    assign bus.first_fail_addr = firstFailAddr_q;
    assign bus.test_done       = (state_q == DONE);
    assign bus.pass            = (state_q == DONE) && !fail_q;
    assign bus.log_valid       = !logEmpty;
    assign bus.log_addr        = logHead[LOG_W-1:DATA_WIDTH];
    assign bus.log_syndrome    = logHead[DATA_WIDTH-1:0];
    assign bus.log_overflow    = overflow_q;

endmodule

// File: doc/bist_checker.md
# bist_checker

Response analyzer for the BIST datapath. Sits beside the March pattern generators, on the SRAM read-data side. Each cycle it captures the generator's read requests (address and expected word) into a delay pipeline matched to SRAM read latency, then compares the returned data. It reports pass/fail, a saturating failure count, the first failing address, and a small FIFO log of failing addresses and syndromes for the scan/host side.

## Interface
Parameters:
- ADDR_WIDTH, 8, SRAM word-address width.
- DATA_WIDTH, 32, SRAM data width.
- READ_LATENCY, 1, clock edges from request sampling to compare; legal range 1..4.
- LOG_DEPTH, 4, failure-log FIFO entries; power of two, at least 2.

Ports (clock and reset first; reset is asynchronous and active-low):
- clk  in  1  single block clock, shared with generator and SRAM.
- rstb  in  1  asynchronous active-low reset.
- clear  in  1  synchronous restart: returns the block to IDLE and clears all results and the log.
- en  in  1  generator step enable; a request is issued only when en=1.
- re  in  1  generator read strobe.
- addr  in  ADDR_WIDTH  generator address.
- expected  in  DATA_WIDTH  generator expected word.
- gen_done  in  1  generator done level.
- dout  in  DATA_WIDTH  SRAM read data.
- fail  out  1  sticky; set on any mismatch.
- fail_count  out  16  mismatch count, saturating at 16'hFFFF.
- first_fail_addr  out  ADDR_WIDTH  address of the first mismatch.
- test_done  out  1  high in DONE.
- pass  out  1  equals test_done && !fail.
- log_valid  out  1  FIFO not empty.
- log_ready  in  1  consumer pop.
- log_addr  out  ADDR_WIDTH  head-entry address.
- log_syndrome  out  DATA_WIDTH  head-entry syndrome, dout ^ expected.
- log_overflow  out  1  sticky; set when a failure is dropped because the FIFO is full.

## Operation
- Request capture: a request is issued when en && re is high at a rising edge. Each edge pushes {valid = en && re, addr, expected} into stage 1 of the delay pipeline; every stage shifts on every edge, whatever the value of en.
- Compare: when stage READ_LATENCY is valid and dout != expected_d, a mismatch occurs and is acted on at that edge.
- On a mismatch:
  - fail is set.
  - fail_count increments unless already 16'hFFFF.
  - first_fail_addr is loaded only if fail was 0.
  - A log entry is pushed.
- Mismatches are evaluated in IDLE, RUN and DRAIN, not in DONE.
- FSM states (from a shared package):
  - IDLE to RUN when en=1.
  - RUN to DRAIN when gen_done=1.
  - DRAIN to DONE when all pipeline valid bits are 0, including the valid bit shifting in that edge.
  - DONE holds until clear or rstb.
- In DRAIN and DONE, no new requests enter the pipeline: stage 1 valid is forced to 0.
- clear takes priority over everything else. At that edge the FSM goes to IDLE, the pipeline valids, fail, fail_count, first_fail_addr, log_overflow and the FIFO are cleared, and any mismatch at the same edge is discarded.
- FIFO push rule: a push is accepted if the FIFO is not full, or if full && log_valid && log_ready (simultaneous pop). Otherwise the entry is dropped and log_overflow is set.
- FIFO pop: occurs when log_valid && log_ready. Popping while empty has no effect.

## Timing
- Reset values of all outputs are 0. FIFO empty, FSM in IDLE, pipeline valids 0.
- A request issued at edge k is compared at edge k+READ_LATENCY. dout must be valid in the cycle just before that edge.
- fail, fail_count, first_fail_addr and the log update at the compare edge and are visible the following cycle.
- log_valid rises one cycle after the first push. log_addr and log_syndrome are registered FIFO head outputs, stable while log_valid && !log_ready.
- test_done rises at most READ_LATENCY+1 edges after gen_done is first sampled high.
- rstb assertion mid-run clears everything immediately, asynchronously. Deassertion is synchronized externally.

## Structure
- Package bist_checker_pkg holds:
  - typedef enum bist_checker_state_t {IDLE, RUN, DRAIN, DONE};
  - localparam FAIL_COUNT_WIDTH = 16.
- Sub-module bist_fail_log: synchronous FIFO with parameters DEPTH and WIDTH (= ADDR_WIDTH + DATA_WIDTH), push/pop/full/empty, asynchronous active-low reset, synchronous clear.
- Top level contains the delay pipeline, comparator, counters and FSM.

## Test plan
- Clean run, READ_LATENCY=1: 16 reads with dout equal to expected, then gen_done. Required: test_done 2 edges later, pass=1, fail_count=0, log_valid=0.
- Single fault, READ_LATENCY=2: read at addr 8'h05 expecting 32'hFFFFFFFF, dout=32'hFFFFFFFE. Required: fail=1, fail_count=1, first_fail_addr=8'h05, log entry {8'h05, 32'h00000001}, pass=0 at DONE.
- Overflow: 6 mismatches with LOG_DEPTH=4 and log_ready=0. Required: fail_count=6, exactly 4 entries retained in order, log_overflow=1. A simultaneous push while full with log_ready=1 is not dropped.
- Saturation: force fail_count to 16'hFFFE, then 3 mismatches. Required: fail_count holds at 16'hFFFF.
- clear on the same edge as a mismatch. Required: all results 0, FSM in IDLE. The next run behaves like the clean run.
- rstb pulsed low mid-DRAIN. Required: all outputs 0 asynchronously. No compare is performed for in-flight requests.
